// File: rtl/pasta_pkg.sv
// Shared PASTA datapath constants and the lane type used by the encryption and decryption stages.
package pasta_pkg;
    localparam int BITLEN  = 17;
    localparam int Q       = 65537;
    localparam int PASTA_S = 32;

    typedef logic [BITLEN-1:0] lane_t;
endpackage

// File: rtl/pasta_modsub_lane.sv
// Single-lane (a - b) mod Q for the decryption combiner.
// PASTA_DEC_RANGE_CHECK_EN adds an out-of-range flag on a and forces the lane result to 0.
module pasta_modsub_lane
    import pasta_pkg::*;
#(
    parameter int BITLEN = pasta_pkg::BITLEN,
    parameter int Q      = pasta_pkg::Q
) (
    input  logic [BITLEN-1:0] a,
    input  logic [BITLEN-1:0] b,
`ifdef PASTA_DEC_RANGE_CHECK_EN
    output logic              oor,
`endif
    output logic [BITLEN-1:0] res
);
    localparam logic [BITLEN:0] Q_EXT = (BITLEN+1)'(Q);

    logic [BITLEN:0]   diff;
    logic [BITLEN-1:0] wrapped;

    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        // Borrow case adds Q back; the sum always fits in BITLEN for in-range inputs.
        wrapped = BITLEN'((a >= b) ? diff : diff + Q_EXT);
    end

`ifdef PASTA_DEC_RANGE_CHECK_EN
    assign oor = ({1'b0, a} >= Q_EXT);
    assign res = oor ? '0 : wrapped;
`else
    assign res = wrapped;
`endif
endmodule

// File: rtl/pasta_dec_sub.sv
// PASTA decryption combiner: keystream FIFO, lane-wise ct - ks mod Q, registered output with backpressure.
// Optional range check on ciphertext lanes is enabled by defining PASTA_DEC_RANGE_CHECK_EN.
module pasta_dec_sub
    import pasta_pkg::*;
#(
    parameter int BITLEN   = pasta_pkg::BITLEN,
    parameter int Q        = pasta_pkg::Q,
    parameter int PASTA_S  = pasta_pkg::PASTA_S,
    parameter int KS_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITLEN*PASTA_S-1:0]     ks_data,
    input  logic                          ks_valid,
    output logic                          ks_ready,
    input  logic [BITLEN*PASTA_S-1:0]     ct_data,
    input  logic                          ct_valid,
    output logic                          ct_ready,
    output logic [BITLEN*PASTA_S-1:0]     pt_data,
    output logic                          pt_valid,
    input  logic                          pt_ready,
    output logic                          pt_err,
    output logic [$clog2(KS_DEPTH):0]     ks_level
);
    localparam int PW = $clog2(KS_DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = BITLEN * PASTA_S;
    localparam logic [LW-1:0] LVL_FULL = LW'(KS_DEPTH);

    logic [DW-1:0] mem_q [KS_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] pt_data_q, pt_data_d;
    logic          pt_valid_q, pt_valid_d;
    logic          pt_err_q, pt_err_d;

    logic          push, fire, out_free;
    logic [DW-1:0] ks_head, lane_res;

    // Readiness looks only at registered occupancy, so a pop never frees a slot for a same-cycle push.
    assign ks_ready = (level_q != LVL_FULL);
    assign push     = ks_valid && ks_ready;
    assign out_free = !pt_valid_q || pt_ready;
    assign fire     = ct_valid && (level_q != '0) && out_free;
    assign ct_ready = fire;
    assign ks_head  = mem_q[rd_ptr_q];

`ifdef PASTA_DEC_RANGE_CHECK_EN
    logic [PASTA_S-1:0] lane_oor;
`endif

    for (genvar gi = 0; gi < PASTA_S; gi++) begin : g_lane
        pasta_modsub_lane #(
            .BITLEN(BITLEN),
            .Q     (Q)
        ) u_lane (
            .a  (ct_data[gi*BITLEN +: BITLEN]),
            .b  (ks_head[gi*BITLEN +: BITLEN]),
`ifdef PASTA_DEC_RANGE_CHECK_EN
            .oor(lane_oor[gi]),
`endif
            .res(lane_res[gi*BITLEN +: BITLEN])
        );
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (fire) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, fire})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        pt_valid_d = pt_valid_q;
        pt_data_d  = pt_data_q;
        pt_err_d   = pt_err_q;
        if (fire) begin
            pt_valid_d = 1'b1;
            pt_data_d  = lane_res;
`ifdef PASTA_DEC_RANGE_CHECK_EN
            pt_err_d   = |lane_oor;
`endif
        end else if (pt_ready) begin
            pt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pt_valid_q <= 1'b0;
            pt_data_q  <= '0;
            pt_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pt_valid_q <= pt_valid_d;
            pt_data_q  <= pt_data_d;
            pt_err_q   <= pt_err_d;
        end
    end

    // Storage needs no reset: clearing the pointers and level discards its contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ks_data;
    end

    assign pt_valid = pt_valid_q;
    assign pt_data  = pt_data_q;
    assign ks_level = level_q;
`ifdef PASTA_DEC_RANGE_CHECK_EN
    assign pt_err = pt_err_q;
`else
    assign pt_err = 1'b0;
`endif
endmodule

// File: doc/pasta_dec_sub.md
# pasta_dec_sub

Decryption-side keystream combiner for the PASTA datapath. It buffers 32-lane keystream blocks from the permutation and subtracts them lane-wise, mod q = 65537, from incoming ciphertext blocks. It emits plaintext blocks through a registered, backpressure-capable output stage. It is the inverse of the encryption-side modular-add stage and uses the same 17-bit-per-lane packing.

## Interface
Parameters:
- BITLEN, 17, lane width in bits
- Q, 65537, modulus
- PASTA_S, 32, lanes per block
- KS_DEPTH, 2, keystream FIFO depth in blocks (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- ks_data  in  BITLEN*PASTA_S  keystream block; lane i is at bits [BITLEN*(i+1)-1 : BITLEN*i]
- ks_valid  in  1  keystream block offered
- ks_ready  out  1  FIFO can accept a keystream block
- ct_data  in  BITLEN*PASTA_S  ciphertext block, same packing as ks_data
- ct_valid  in  1  ciphertext block offered
- ct_ready  out  1  ciphertext accepted this cycle
- pt_data  out  BITLEN*PASTA_S  plaintext block
- pt_valid  out  1  plaintext block held
- pt_ready  in  1  downstream accepts
- pt_err  out  1  range error for the held block (see Configuration)
- ks_level  out  $clog2(KS_DEPTH)+1  keystream FIFO occupancy

## Operation
- Keystream FIFO:
  - Circular buffer of KS_DEPTH blocks with read and write pointers that wrap at KS_DEPTH.
  - Push: ks_valid && ks_ready.
  - ks_ready = (ks_level != KS_DEPTH). It depends only on registered occupancy; a same-cycle pop does not free a slot for a push while full.
- Output slot free: out_free = !pt_valid || pt_ready.
- Fire: ct_valid && (ks_level != 0) && out_free.
  - ct_ready = fire. The ready is not asserted while the FIFO is empty or the output is stalled.
  - On fire: pop the FIFO head and load pt_data with the lane results.
- Lane arithmetic, with a = ct lane and b = ks head lane:
  - Compute d = a − b at BITLEN+1 bits.
  - If a ≥ b, result = d; otherwise result = d + Q. Truncate to BITLEN.
  - For inputs below Q, the result is always below Q.
- Output register:
  - pt_valid is set on fire.
  - pt_valid is cleared when pt_ready is high and there is no fire in the same cycle.
  - pt_data and pt_err hold while pt_valid && !pt_ready.
- Simultaneous events:
  - Push and pop in the same cycle with level in 1..KS_DEPTH−1: level is unchanged and both pointers advance.
  - Push into an empty FIFO: the pushed block becomes poppable on the next cycle, with no fall-through.
- Reset, including mid-operation:
  - Pointers reset to 0, ks_level to 0, pt_valid to 0, pt_data to 0, pt_err to 0.
  - Buffered keystream is discarded.
  - ks_ready becomes 1 immediately (combinational from level).
  - ct_ready is 0 until a keystream block has been accepted.

## Timing
- Latency: one cycle. A fire at edge N gives pt_valid high after edge N.
- Throughput: one block per cycle while keystream is available and pt_ready is held high.
- Keystream path: a block pushed at edge N can fire at edge N+1 at the earliest.
- Outputs are registered except ks_ready and ct_ready, which are combinational from registered state and the inputs ct_valid and pt_ready.

## Configuration
- PASTA_DEC_RANGE_CHECK_EN defined:
  - Each ciphertext lane is compared against Q at fire.
  - Any lane ≥ Q sets pt_err for that block, and the offending lanes output 0. Other lanes are computed normally.
  - pt_err is cleared by the next fire that has no violations.
- PASTA_DEC_RANGE_CHECK_EN undefined:
  - pt_err is tied to 0 and no comparators are built.
  - Output for out-of-range input is unspecified.

## Structure
- Shared package pasta_pkg holds BITLEN, Q, PASTA_S and a lane typedef (logic [BITLEN-1:0]).
- One sub-module, pasta_modsub_lane: combinational single-lane a−b mod Q, plus the range flag when enabled. It is instantiated PASTA_S times in a generate loop.
- FIFO and output register live in the top module.

## Test plan
- Basic subtract: ks lane 0 = 10, ct lane 0 = 5 → pt lane 0 = 65532. With ks = 3, ct = 9 → 6. The result appears one cycle after fire.
- Boundary: ct = 0, ks = 1 → 65536. ct = 65536, ks = 65536 → 0. ct = 65536, ks = 0 → 65536. All 32 lanes use distinct values to check lane packing.
- FIFO fill: push 2 keystream blocks with ct_valid low → ks_level = 2, ks_ready = 0. A third push is refused. Then one ct fire → level 1, ks_ready = 1.
- Backpressure: hold pt_ready = 0 across 3 ct offers → exactly one fire, pt_data stable, ct_ready = 0. Release → the next block fires in the same cycle the held one is taken.
- Async reset mid-stream with level 1 and pt_valid = 1 → pt_valid = 0 and ks_level = 0 without waiting for a clock edge. ct_ready stays 0 until a new keystream push.
- With PASTA_DEC_RANGE_CHECK_EN: ct lane 3 = 65537 → pt_err = 1, pt lane 3 = 0, other lanes correct. The next clean block → pt_err = 0.
